pc_seq_unit: RTL and testbench

PC_SEQ_UNIT -- requirements
Module: pc_seq_unit

---
 rtl/pc_seq_unit_pkg.sv | 17 +
 rtl/pc_seq_unit_ras_stack.sv | 58 +++++
 rtl/pc_seq_unit.sv | 108 ++++++++++
 tb/tb_pc_seq_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_unit_pkg.sv
// Shared definitions for the PC sequencing unit: next-PC mode encodings and
// default reset/exception vectors.
package pc_seq_unit_pkg;

  typedef enum logic [2:0] {
    PC_SEQ  = 3'd0,
    PC_BR   = 3'd1,
    PC_J    = 3'd2,
    PC_JR   = 3'd3,
    PC_CALL = 3'd4,
    PC_RET  = 3'd5
  } pc_mode_e;

  localparam logic [63:0] DEF_RESET_VECTOR = 64'h0;
  localparam logic [63:0] DEF_EXC_VECTOR   = 64'h80;

endpackage

// File: rtl/pc_seq_unit_ras_stack.sv
// Return-address stack: circular buffer that overwrites the oldest entry when
// pushed while full; count saturates at DEPTH.
module ras_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wp_q, wp_d, rd_idx;
  logic [CW-1:0]    cnt_q, cnt_d;

  // wp_q is the next write slot; the top of stack sits one slot below it.
  always_comb begin
    mem_d  = mem_q;
    wp_d   = wp_q;
    cnt_d  = cnt_q;
    rd_idx = (wp_q == '0) ? PW'(DEPTH - 1) : wp_q - PW'(1);
    if (push) begin
      mem_d[wp_q] = din;
      wp_d        = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
      if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
    end else if (pop && (cnt_q != '0)) begin
      wp_d  = rd_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst_n) begin
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_idx];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: registered PC with combinational next-PC select
// (seq/branch/jump/register jump/call/return) and a return-address stack.
module pc_seq_unit
  import pc_seq_unit_pkg::*;
#(
  parameter int unsigned      N_BIT        = 32,
  parameter int unsigned      RAS_DEPTH    = 4,
  parameter logic [N_BIT-1:0] RESET_VECTOR = N_BIT'(DEF_RESET_VECTOR),
  parameter logic [N_BIT-1:0] EXC_VECTOR   = N_BIT'(DEF_EXC_VECTOR)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             exc_req,
  input  logic [2:0]       mode,
  input  logic             branch_taken,
  input  logic [15:0]      imm,
  input  logic [25:0]      jump_target,
  input  logic [N_BIT-1:0] reg_target,
  output logic [N_BIT-1:0] pc,
  output logic [N_BIT-1:0] pc_plus4,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow,
  output logic             misalign
);

  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [N_BIT-1:0] pc_q, pc_d;
  logic [N_BIT-1:0] ras_dout, br_target, j_target, jr_target;
  logic [CW-1:0]    ras_count;
  logic             und_q, und_d, mis_q, mis_d;
  logic             push, pop;

  assign pc_plus4  = pc_q + N_BIT'(4);
  assign br_target = pc_plus4 + N_BIT'({{46{imm[15]}}, imm, 2'b00});
  // Built at 64 bits so the upper-PC splice degrades to plain truncation when N_BIT <= 28.
  assign j_target  = N_BIT'((64'(pc_plus4) & ~64'h0FFF_FFFF) | 64'({jump_target, 2'b00}));
  assign jr_target = {reg_target[N_BIT-1:2], 2'b00};

  always_comb begin
    pc_d  = pc_q;
    und_d = 1'b0;
    mis_d = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    if (exc_req) begin
      pc_d = {EXC_VECTOR[N_BIT-1:2], 2'b00};
    end else if (!stall) begin
      case (mode)
        PC_BR:   pc_d = branch_taken ? br_target : pc_plus4;
        PC_J:    pc_d = j_target;
        PC_JR: begin
          pc_d  = jr_target;
          mis_d = |reg_target[1:0];
        end
        PC_CALL: begin
          pc_d = j_target;
          push = 1'b1;
        end
        PC_RET: begin
          if (ras_count != '0) begin
            pc_d = ras_dout;
            pop  = 1'b1;
          end else begin
            pc_d  = jr_target;
            und_d = 1'b1;
            mis_d = |reg_target[1:0];
          end
        end
        default: pc_d = pc_plus4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q  <= {RESET_VECTOR[N_BIT-1:2], 2'b00};
      und_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      und_q <= und_d;
      mis_q <= mis_d;
    end
  end

  ras_stack #(
    .WIDTH (N_BIT),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_plus4),
    .dout  (ras_dout),
    .count (ras_count),
    .empty (ras_empty),
    .full  (ras_full)
  );

  assign pc            = pc_q;
  assign ras_underflow = und_q;
  assign misalign      = mis_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: directed scenarios plus randomized traffic checked
// against a queue-based reference model (32-bit/depth-2 and 8-bit instances).
module tb_pc_seq_unit;
  import pc_seq_unit_pkg::*;

  localparam int unsigned A_DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance A: 32-bit PC, 2-entry stack
  logic        a_rst_n, a_stall, a_exc, a_bt;
  logic [2:0]  a_mode;
  logic [15:0] a_imm;
  logic [25:0] a_jt;
  logic [31:0] a_rt, a_pc, a_pc4;
  logic        a_empty, a_full, a_und, a_mis;

  pc_seq_unit #(.N_BIT(32), .RAS_DEPTH(A_DEPTH)) dut_a (
    .clk(clk), .reset_n(a_rst_n), .stall(a_stall), .exc_req(a_exc),
    .mode(a_mode), .branch_taken(a_bt), .imm(a_imm), .jump_target(a_jt),
    .reg_target(a_rt), .pc(a_pc), .pc_plus4(a_pc4), .ras_empty(a_empty),
    .ras_full(a_full), .ras_underflow(a_und), .misalign(a_mis)
  );

  // Instance B: 8-bit PC, default stack depth
  logic        b_rst_n, b_stall, b_exc, b_bt;
  logic [2:0]  b_mode;
  logic [15:0] b_imm;
  logic [25:0] b_jt;
  logic [7:0]  b_rt, b_pc, b_pc4;
  logic        b_empty, b_full, b_und, b_mis;

  pc_seq_unit #(.N_BIT(8)) dut_b (
    .clk(clk), .reset_n(b_rst_n), .stall(b_stall), .exc_req(b_exc),
    .mode(b_mode), .branch_taken(b_bt), .imm(b_imm), .jump_target(b_jt),
    .reg_target(b_rt), .pc(b_pc), .pc_plus4(b_pc4), .ras_empty(b_empty),
    .ras_full(b_full), .ras_underflow(b_und), .misalign(b_mis)
  );

  // Reference model for instance A
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_und, m_mis;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rn, input logic st, input logic ex,
                            input logic [2:0] md, input logic bt, input logic [15:0] im,
                            input logic [25:0] jt, input logic [31:0] rt);
    logic [31:0] p4;
    int          off;
    p4    = m_pc + 32'd4;
    off   = int'($signed(im)) * 4;
    m_und = 1'b0;
    m_mis = 1'b0;
    if (!rn) begin
      m_pc = 32'h0;
      m_ras.delete();
    end else if (ex) begin
      m_pc = 32'h80;
    end else if (!st) begin
      case (md)
        3'd1: m_pc = bt ? p4 + 32'(off) : p4;
        3'd2: m_pc = {p4[31:28], jt, 2'b00};
        3'd3: begin
          m_pc  = rt & ~32'd3;
          m_mis = (rt % 4) != 0;
        end
        3'd4: begin
          if (m_ras.size() == A_DEPTH) void'(m_ras.pop_front());
          m_ras.push_back(p4);
          m_pc = {p4[31:28], jt, 2'b00};
        end
        3'd5: begin
          if (m_ras.size() > 0) m_pc = m_ras.pop_back();
          else begin
            m_pc  = rt & ~32'd3;
            m_und = 1'b1;
            m_mis = (rt % 4) != 0;
          end
        end
        default: m_pc = p4;
      endcase
    end
  endtask

  task automatic step(input logic rn, input logic st, input logic ex,
                      input logic [2:0] md, input logic bt, input logic [15:0] im,
                      input logic [25:0] jt, input logic [31:0] rt);
    a_rst_n = rn; a_stall = st; a_exc = ex; a_mode = md;
    a_bt = bt; a_imm = im; a_jt = jt; a_rt = rt;
    @(posedge clk);
    model_edge(rn, st, ex, md, bt, im, jt, rt);
    #1;
    chk("a_pc", a_pc, m_pc);
    chk("a_pc_plus4", a_pc4, m_pc + 32'd4);
    chk("a_ras_empty", a_empty, m_ras.size() == 0);
    chk("a_ras_full", a_full, m_ras.size() == A_DEPTH);
    chk("a_underflow", a_und, m_und);
    chk("a_misalign", a_mis, m_mis);
  endtask

  task automatic bstep(input logic rn, input logic [2:0] md, input logic [25:0] jt,
                       input logic [7:0] rt);
    b_rst_n = rn; b_stall = 1'b0; b_exc = 1'b0; b_mode = md;
    b_bt = 1'b0; b_imm = '0; b_jt = jt; b_rt = rt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst_n = 1'b0; a_stall = 1'b0; a_exc = 1'b0; a_mode = '0;
    a_bt = 1'b0; a_imm = '0; a_jt = '0; a_rt = '0;
    b_rst_n = 1'b0; b_stall = 1'b0; b_exc = 1'b0; b_mode = '0;
    b_bt = 1'b0; b_imm = '0; b_jt = '0; b_rt = '0;

    // Reset then sequential fetch
    step(0, 0, 0, PC_SEQ, 0, 0, 0, 0);
    step(0, 0, 0, PC_SEQ, 0, 0, 0, 0);
    chk("reset_pc", a_pc, 32'h0);
    chk("reset_empty", a_empty, 1'b1);
    step(1, 0, 0, PC_SEQ, 0, 0, 0, 0); chk("seq1", a_pc, 32'h4);
    step(1, 0, 0, PC_SEQ, 0, 0, 0, 0); chk("seq2", a_pc, 32'h8);
    step(1, 0, 0, PC_SEQ, 0, 0, 0, 0); chk("seq3", a_pc, 32'hC);

    // Branch taken / not taken
    step(1, 0, 0, PC_JR, 0, 0, 0, 32'h100);
    step(1, 0, 0, PC_BR, 1, 16'hFFFE, 0, 0); chk("br_taken", a_pc, 32'hFC);
    step(1, 0, 0, PC_JR, 0, 0, 0, 32'h100);
    step(1, 0, 0, PC_BR, 0, 16'hFFFE, 0, 0); chk("br_not_taken", a_pc, 32'h104);

    // Call / return
    step(1, 0, 0, PC_JR, 0, 0, 0, 32'h40);
    step(1, 0, 0, PC_CALL, 0, 0, 26'h100, 0); chk("call_pc", a_pc, 32'h400);
    step(1, 0, 0, PC_RET, 0, 0, 0, 0);
    chk("ret_pc", a_pc, 32'h44);
    chk("ret_empty", a_empty, 1'b1);

    // Overflow with circular overwrite, then underflow fallback
    step(1, 0, 0, PC_CALL, 0, 0, 26'h10, 0);
    step(1, 0, 0, PC_CALL, 0, 0, 26'h20, 0);
    step(1, 0, 0, PC_CALL, 0, 0, 26'h30, 0);
    chk("ovf_full", a_full, 1'b1);
    step(1, 0, 0, PC_RET, 0, 0, 0, 0); chk("ret_3rd", a_pc, 32'h84);
    step(1, 0, 0, PC_RET, 0, 0, 0, 0); chk("ret_2nd", a_pc, 32'h44);
    step(1, 0, 0, PC_RET, 0, 0, 0, 32'h203);
    chk("und_pc", a_pc, 32'h200);
    chk("und_flag", a_und, 1'b1);
    chk("und_mis", a_mis, 1'b1);
    step(1, 0, 0, PC_SEQ, 0, 0, 0, 0); chk("pulse_clear", a_und, 1'b0);

    // Priority: stall over mode, exception over stall
    step(1, 1, 0, PC_J, 0, 0, 26'h3FF, 0); chk("stall_hold", a_pc, 32'h204);
    step(1, 0, 0, PC_CALL, 0, 0, 26'h50, 0);
    step(1, 1, 1, PC_RET, 0, 0, 0, 0);
    chk("exc_pc", a_pc, 32'h80);
    chk("exc_stack_kept", a_empty, 1'b0);
    step(1, 0, 0, PC_RET, 0, 0, 0, 0); chk("exc_ret", a_pc, 32'h208);

    // Reset during CALL discards the push
    step(1, 0, 0, PC_CALL, 0, 0, 26'h60, 0);
    step(0, 0, 0, PC_CALL, 0, 0, 26'h70, 0);
    chk("rst_call_pc", a_pc, 32'h0);
    chk("rst_call_empty", a_empty, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)), 1'($urandom),
           16'($urandom), 26'($urandom), $urandom);
    end

    // 8-bit instance: wrap-around and reset during CALL
    bstep(0, PC_SEQ, 0, 0);
    chk("b_reset_pc", b_pc, 8'h00);
    bstep(1, PC_JR, 0, 8'hFC);
    chk("b_jr_pc", b_pc, 8'hFC);
    chk("b_pc_plus4_wrap", b_pc4, 8'h00);
    bstep(1, PC_SEQ, 0, 0);
    chk("b_seq_wrap", b_pc, 8'h00);
    bstep(1, PC_CALL, 26'h3, 0);
    chk("b_call_pc", b_pc, 8'h0C);
    chk("b_call_nonempty", b_empty, 1'b0);
    bstep(0, PC_CALL, 26'h5, 0);
    chk("b_rst_call_pc", b_pc, 8'h00);
    chk("b_rst_call_empty", b_empty, 1'b1);
    bstep(1, PC_RET, 0, 8'h10);
    chk("b_ret_empty_pc", b_pc, 8'h10);
    chk("b_ret_underflow", b_und, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
